// File: rtl/fp_rf_write_arbiter.sv
// Two-requester round-robin write port for the FP register file, with registered WE/RW/DW.
// Define FP_RF_ZERO_INIT_EN to zero every entry after reset before requests are accepted.
module fp_rf_write_arbiter #(
    parameter int NUM_REGS = 80,
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 64
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              A_VALID,
    output logic              A_READY,
    input  logic [ADDR_W-1:0] A_ADDR,
    input  logic [DATA_W-1:0] A_DATA,
    input  logic              B_VALID,
    output logic              B_READY,
    input  logic [ADDR_W-1:0] B_ADDR,
    input  logic [DATA_W-1:0] B_DATA,
    output logic              WE,
    output logic [ADDR_W-1:0] RW,
    output logic [DATA_W-1:0] DW,
    output logic              INIT_DONE,
    output logic              ERR,
    input  logic              ERR_CLR,
    output logic              DBG_STATE
);

    // Handshake: a requester transfers when its VALID and READY are both high at a
    // rising CLK edge; READY never depends on the same requester's READY, only on
    // both VALIDs, INIT_DONE and the round-robin pointer.

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int AW1 = ADDR_W + 1;

    localparam state_t RESET_STATE =
`ifdef FP_RF_ZERO_INIT_EN
        ST_INIT;
`else
        ST_RUN;
`endif

    state_t            state;
    logic [ADDR_W-1:0] init_cnt;
    logic              last_b;
    logic              fire;
    logic              sel_oob;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // last_b=1 means B won last, so A wins the next contention.
    always_comb begin
        A_READY  = INIT_DONE & A_VALID & (~B_VALID | last_b);
        B_READY  = INIT_DONE & B_VALID & (~A_VALID | ~last_b);
        fire     = A_READY | B_READY;
        sel_addr = B_READY ? B_ADDR : A_ADDR;
        sel_data = B_READY ? B_DATA : A_DATA;
        sel_oob  = {1'b0, sel_addr} >= AW1'(NUM_REGS);
    end

    assign DBG_STATE = state;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= RESET_STATE;
            init_cnt  <= '0;
            last_b    <= 1'b1;
            WE        <= 1'b0;
            RW        <= '0;
            DW        <= '0;
            ERR       <= 1'b0;
            INIT_DONE <= 1'b0;
        end else begin
            // A new out-of-range acceptance wins over a clear in the same cycle.
            if (fire && sel_oob) begin
                ERR <= 1'b1;
            end else if (ERR_CLR) begin
                ERR <= 1'b0;
            end

            if (fire) begin
                last_b <= B_READY;
            end

            case (state)
                ST_INIT: begin
                    WE <= 1'b1;
                    RW <= init_cnt;
                    DW <= '0;
                    if (init_cnt == ADDR_W'(NUM_REGS - 1)) begin
                        state <= ST_RUN;
                    end else begin
                        init_cnt <= init_cnt + ADDR_W'(1);
                    end
                end
                ST_RUN: begin
                    INIT_DONE <= 1'b1;
                    WE        <= fire & ~sel_oob;
                    // RW/DW keep their last value when nothing is written.
                    if (fire && !sel_oob) begin
                        RW <= sel_addr;
                        DW <= sel_data;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_rf_write_arbiter.sv
// Directed bench for fp_rf_write_arbiter; covers both the default and FP_RF_ZERO_INIT_EN builds.
module tb_fp_rf_write_arbiter;

    localparam int NUM_REGS = 80;
    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 64;

    // Clock/reset block
    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    logic              A_VALID = 1'b0;
    logic              A_READY;
    logic [ADDR_W-1:0] A_ADDR = '0;
    logic [DATA_W-1:0] A_DATA = '0;
    logic              B_VALID = 1'b0;
    logic              B_READY;
    logic [ADDR_W-1:0] B_ADDR = '0;
    logic [DATA_W-1:0] B_DATA = '0;
    logic              WE;
    logic [ADDR_W-1:0] RW;
    logic [DATA_W-1:0] DW;
    logic              INIT_DONE;
    logic              ERR;
    logic              ERR_CLR = 1'b0;
    logic              DBG_STATE;

    fp_rf_write_arbiter #(
        .NUM_REGS(NUM_REGS),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .A_VALID  (A_VALID),
        .A_READY  (A_READY),
        .A_ADDR   (A_ADDR),
        .A_DATA   (A_DATA),
        .B_VALID  (B_VALID),
        .B_READY  (B_READY),
        .B_ADDR   (B_ADDR),
        .B_DATA   (B_DATA),
        .WE       (WE),
        .RW       (RW),
        .DW       (DW),
        .INIT_DONE(INIT_DONE),
        .ERR      (ERR),
        .ERR_CLR  (ERR_CLR),
        .DBG_STATE(DBG_STATE)
    );

    int chk_cnt = 0;
    int err_cnt = 0;
    logic [DATA_W-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Driver tasks: inputs change 1 ns after a rising edge, outputs are sampled there too.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        A_VALID = 1'b0;
        B_VALID = 1'b0;
        ERR_CLR = 1'b0;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        idle_inputs();
        tick();
        tick();
        check_eq("rst_we", 64'(WE), 64'd0);
        check_eq("rst_rw", 64'(RW), 64'd0);
        check_eq("rst_dw", DW, 64'd0);
        check_eq("rst_err", 64'(ERR), 64'd0);
        check_eq("rst_init_done", 64'(INIT_DONE), 64'd0);
        RST_N = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_a;
`ifdef FP_RF_ZERO_INIT_EN
        // Reset dropped at init write RW=40 aborts; init restarts from 0.
        do_reset();
        A_VALID = 1'b1;
        B_VALID = 1'b1;
        for (int i = 0; i <= 40; i++) begin
            tick();
            check_eq("part_init_rw", 64'(RW), 64'(i));
        end
        RST_N = 1'b0;
        #1;
        check_eq("abort_we", 64'(WE), 64'd0);
        check_eq("abort_rw", 64'(RW), 64'd0);
        tick();
        RST_N = 1'b1;
        tick();
        check_eq("restart_we", 64'(WE), 64'd1);
        check_eq("restart_rw", 64'(RW), 64'd0);

        // Full zero-init with both requesters held valid.
        do_reset();
        A_VALID = 1'b1;
        B_VALID = 1'b1;
        #1;
        check_eq("init_a_ready0", 64'(A_READY), 64'd0);
        for (int i = 0; i < NUM_REGS; i++) begin
            tick();
            check_eq("init_we", 64'(WE), 64'd1);
            check_eq("init_rw", 64'(RW), 64'(i));
            check_eq("init_dw", DW, 64'd0);
            check_eq("init_done_low", 64'(INIT_DONE), 64'd0);
            check_eq("init_no_ready", 64'({A_READY, B_READY}), 64'd0);
        end
        tick();
        check_eq("init_done_81", 64'(INIT_DONE), 64'd1);
        check_eq("init_we_81", 64'(WE), 64'd0);
        idle_inputs();
`else
        do_reset();
        A_VALID = 1'b1;
        A_ADDR  = 7'd3;
        A_DATA  = 64'h55;
        #1;
        check_eq("pre_edge_a_ready", 64'(A_READY), 64'd0);
        tick();
        check_eq("edge1_init_done", 64'(INIT_DONE), 64'd1);
        check_eq("edge1_no_zero_write", 64'(WE), 64'd0);
        check_eq("edge1_a_ready", 64'(A_READY), 64'd1);
        tick();
        check_eq("first_we", 64'(WE), 64'd1);
        check_eq("first_rw", 64'(RW), 64'd3);
        check_eq("first_dw", DW, 64'h55);
        idle_inputs();
`endif
        check_eq("dbg_state_run", 64'(DBG_STATE), 64'd1);

        // A alone.
        A_VALID = 1'b1;
        A_ADDR  = 7'd5;
        A_DATA  = 64'h3FF0000000000000;
        #1;
        check_eq("a_alone_ready", 64'(A_READY), 64'd1);
        check_eq("a_alone_b_ready", 64'(B_READY), 64'd0);
        tick();
        check_eq("a_alone_we", 64'(WE), 64'd1);
        check_eq("a_alone_rw", 64'(RW), 64'd5);
        check_eq("a_alone_dw", DW, 64'h3FF0000000000000);

        // Idle cycle: WE drops, RW/DW hold.
        idle_inputs();
        tick();
        check_eq("idle_we", 64'(WE), 64'd0);
        check_eq("idle_rw_hold", 64'(RW), 64'd5);
        check_eq("idle_dw_hold", DW, 64'h3FF0000000000000);

        // B out of range: handshake completes, no write, sticky ERR, then clear.
        B_VALID = 1'b1;
        B_ADDR  = 7'd80;
        B_DATA  = 64'h1234;
        #1;
        check_eq("oob_b_ready", 64'(B_READY), 64'd1);
        tick();
        check_eq("oob_we", 64'(WE), 64'd0);
        check_eq("oob_err", 64'(ERR), 64'd1);
        check_eq("oob_rw_hold", 64'(RW), 64'd5);
        idle_inputs();
        tick();
        check_eq("err_sticky", 64'(ERR), 64'd1);
        ERR_CLR = 1'b1;
        tick();
        check_eq("err_cleared", 64'(ERR), 64'd0);
        ERR_CLR = 1'b0;

        // Continuous contention: B won last, so A,B,A,B,A,B.
        A_VALID = 1'b1;
        B_VALID = 1'b1;
        A_ADDR  = 7'd10;
        B_ADDR  = 7'd20;
        for (int i = 0; i < 6; i++) begin
            A_DATA = 64'hA0 + 64'(i);
            B_DATA = 64'hB0 + 64'(i);
            exp_a  = (i % 2 == 0);
            exp_q.push_back(exp_a ? 64'hA0 + 64'(i) : 64'hB0 + 64'(i));
            #1;
            check_eq("rr_a_ready", 64'(A_READY), 64'(exp_a));
            check_eq("rr_b_ready", 64'(B_READY), 64'(!exp_a));
            tick();
            check_eq("rr_we", 64'(WE), 64'd1);
            check_eq("rr_rw", 64'(RW), exp_a ? 64'd10 : 64'd20);
            check_eq("rr_dw", DW, exp_q.pop_front());
        end
        idle_inputs();

        // Out-of-range acceptance together with ERR_CLR leaves ERR set.
        B_VALID = 1'b1;
        B_ADDR  = 7'd127;
        ERR_CLR = 1'b1;
        tick();
        check_eq("set_clr_err", 64'(ERR), 64'd1);
        check_eq("set_clr_we", 64'(WE), 64'd0);
        B_VALID = 1'b0;
        tick();
        check_eq("clr_after_set", 64'(ERR), 64'd0);
        ERR_CLR = 1'b0;

        // Highest valid address is written normally.
        A_VALID = 1'b1;
        A_ADDR  = 7'd79;
        A_DATA  = 64'h79;
        tick();
        check_eq("top_addr_we", 64'(WE), 64'd1);
        check_eq("top_addr_rw", 64'(RW), 64'd79);
        check_eq("top_addr_err", 64'(ERR), 64'd0);

        // Contention with A out of range: B first (A won last), then A fails.
        B_VALID = 1'b1;
        A_ADDR  = 7'd100;
        B_ADDR  = 7'd7;
        B_DATA  = 64'hBEEF;
        #1;
        check_eq("mix_b_ready", 64'(B_READY), 64'd1);
        check_eq("mix_a_ready", 64'(A_READY), 64'd0);
        tick();
        check_eq("mix_b_rw", 64'(RW), 64'd7);
        check_eq("mix_b_dw", DW, 64'hBEEF);
        check_eq("mix_a_turn", 64'(A_READY), 64'd1);
        tick();
        check_eq("mix_a_we", 64'(WE), 64'd0);
        check_eq("mix_a_rw_hold", 64'(RW), 64'd7);
        check_eq("mix_a_err", 64'(ERR), 64'd1);

        // Reset mid-traffic clears everything asynchronously.
        A_ADDR = 7'd11;
        B_ADDR = 7'd12;
        tick();
        check_eq("traffic_we", 64'(WE), 64'd1);
        check_eq("traffic_rw", 64'(RW), 64'd12);
        RST_N = 1'b0;
        #1;
        check_eq("async_we", 64'(WE), 64'd0);
        check_eq("async_rw", 64'(RW), 64'd0);
        check_eq("async_err", 64'(ERR), 64'd0);
        check_eq("async_init_done", 64'(INIT_DONE), 64'd0);
        check_eq("async_ready", 64'({A_READY, B_READY}), 64'd0);
        idle_inputs();

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/fp_rf_write_arbiter.md
FP_RF_WRITE_ARBITER -- requirements
Module: fp_rf_write_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 80, number of FP register-file entries.
REQ-002 The block SHALL have parameter ADDR_W, default 7, register address width.
REQ-003 The block SHALL have parameter DATA_W, default 64, register data width.
REQ-004 CLK  input  1  sole clock, all state on rising edge.
REQ-005 RST_N  input  1  asynchronous, active-low reset.
REQ-006 A_VALID, A_READY  input/output  1 each  requester A handshake (FPU writeback).
REQ-007 A_ADDR, A_DATA  input  ADDR_W / DATA_W  requester A target register and value.
REQ-008 B_VALID, B_READY  input/output  1 each  requester B handshake (FP load writeback).
REQ-009 B_ADDR, B_DATA  input  ADDR_W / DATA_W  requester B target register and value.
REQ-010 WE  output  1  register-file write enable.
REQ-011 RW, DW  output  ADDR_W / DATA_W  register-file write address and data.
REQ-012 INIT_DONE  output  1  high once the block accepts requests.
REQ-013 ERR  output  1  sticky out-of-range-address flag.
REQ-014 ERR_CLR  input  1  synchronous clear of ERR.

Function
REQ-015 WE, RW and DW SHALL be registered: a transfer accepted in cycle N SHALL appear as WE=1 with its RW and DW in cycle N+1.
REQ-016 A transfer SHALL occur when VALID and READY are both high at a rising edge; READY SHALL be combinational from VALID inputs, INIT_DONE and the arbiter state.
REQ-017 While INIT_DONE=0, A_READY and B_READY SHALL be 0.
REQ-018 With one requester valid, its READY SHALL be 1; with both valid, exactly one READY SHALL be 1, chosen round-robin.
REQ-019 The round-robin pointer SHALL record the last granted requester, and on contention grant the other; after reset the pointer SHALL favour A.
REQ-020 The pointer SHALL update only on an accepted transfer; uncontested grants also update it.
REQ-021 An accepted request with ADDR >= NUM_REGS SHALL complete its handshake, SHALL NOT assert WE, and SHALL set ERR in the next cycle.
REQ-022 ERR SHALL stay set until ERR_CLR=1 at a rising edge with no new out-of-range acceptance in that cycle; simultaneous set and clear SHALL leave ERR=1.
REQ-023 When no transfer is accepted, WE SHALL be 0 next cycle and RW/DW SHALL hold their previous values.
REQ-024 Throughput SHALL be one write per cycle sustained; no request SHALL wait more than one cycle under continuous contention.

Reset
REQ-025 On RST_N=0, WE=0, RW=0, DW=0, ERR=0, INIT_DONE=0 and the pointer SHALL favour A, asynchronously.
REQ-026 Reset asserted mid-initialisation or mid-traffic SHALL abort all activity; any pending write SHALL be lost and the sequence restarts after release.

Configuration
REQ-027 Macro FP_RF_ZERO_INIT_EN SHALL select a zero-initialisation sequencer.
REQ-028 With FP_RF_ZERO_INIT_EN defined: starting the first cycle after RST_N rises, the block SHALL drive WE=1, DW=0, RW=0,1,...,NUM_REGS-1 on consecutive cycles, then assert INIT_DONE in the cycle after RW=NUM_REGS-1.
REQ-029 Without FP_RF_ZERO_INIT_EN: no init writes SHALL occur and INIT_DONE SHALL be 1 from the first rising edge after RST_N rises.
REQ-030 ERR_CLR during initialisation SHALL be honoured; requester VALIDs during initialisation SHALL be ignored, not lost, since READY=0.

Verification
REQ-031 With the macro: release reset, hold both VALIDs high -> cycles 1..80 show WE=1, RW=0..79, DW=0; INIT_DONE=1 at cycle 81; no READY before then.
REQ-032 A alone valid, A_ADDR=5, A_DATA=0x3FF0000000000000 -> A_READY=1; next cycle WE=1, RW=5, DW=0x3FF0000000000000.
REQ-033 A and B continuously valid for 6 cycles after init -> grants A,B,A,B,A,B; WE=1 every cycle.
REQ-034 B valid with B_ADDR=80 -> handshake completes, WE=0 next cycle, ERR=1; ERR_CLR pulse -> ERR=0 the following cycle.
REQ-035 Drop RST_N at init write RW=40 -> WE=0 immediately; after release, init restarts from RW=0.
REQ-036 Without the macro: release reset, A valid at first edge -> INIT_DONE=1, A accepted, no zero writes observed.
